uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
Byte-stream consumer placed directly downstream of the 32-to-8 transmit buffer on the AXI4-Lite-to-UART transmit path. Accepts bytes over a valid/ready handshake into a small internal FIFO and exposes FIFO full status. Serializes each byte onto the UART tx line as 8N1, or 8E1/8O1 when parity is enabled, at a fixed clocks-per-bit rate. Produces the only off-chip transmit signal of the bridge.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2
FIFO_DEPTH, 4, byte FIFO entries; power of two, >= 2
PARITY_EN, 0, 1 = insert parity bit between data and stop
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN = 0)

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
inValid  input  1  upstream byte valid
data_in  input  8  upstream byte
inReady  output  1  byte accepted this cycle when inValid && inReady
full  output  1  FIFO holds FIFO_DEPTH entries
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
busy  output  1  FSM not in IDLE
tx  output  1  UART serial line; idle high

Behaviour:
- Reset (rst sampled high on a clk edge): tx=1, busy=0, full=0, fifo_count=0, inReady=0 while rst is high. FIFO pointers cleared, FSM to IDLE, baud counter and bit index cleared.
- Reset mid-frame aborts the frame: tx=1 on the cycle after the reset edge; queued bytes are discarded.
- inReady = !full and not in reset (combinational from registered full).
- Push when inValid && inReady.
- Upstream may hold inValid high across consecutive bytes; each accepting cycle is exactly one byte.
- A push while full is refused: the byte stays on data_in and is neither lost nor duplicated.
- Simultaneous push and pop while not full: fifo_count unchanged, data order preserved.
- Full is evaluated before the pop, so a full FIFO refuses the push even on a pop cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP (enum in the package).
- IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, go to START, baud counter=0.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. After bit 7, go to PARITY if PARITY_EN, else STOP.
- PARITY: tx = XOR of the 8 data bits, inverted when PARITY_ODD; lasts CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle, if the FIFO is non-empty: pop and go directly to START (no idle gap).
  - Otherwise go to IDLE.
- tx is registered.
- Latency: byte pushed at edge N into an empty FIFO with the FSM in IDLE → popped at edge N+1 → tx falls at edge N+2.
- Frame length: 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Occupancy is tracked in a separate counter, so full and empty are unambiguous at wrap.

Decomposition:
- Package uart_pkg holds:
  - the TX_STATE enum (IDLE, START, DATA, PARITY, STOP);
  - the UART_DATA_W=8 constant;
  - a localparam helper for the default CLKS_PER_BIT.
- One sub-module, uart_byte_fifo (parameter DEPTH), provides:
  - push and pop ports;
  - data, full, empty and count outputs;
  - a synchronous active-high rst.
- The serializer FSM and baud counter stay in uart_tx_serializer.

Test Plan:
1. CLKS_PER_BIT=4, PARITY_EN=0, push 0xA5 once → tx sequence 0,1,0,1,0,0,1,0,1,1, each level 4 cycles. tx falls 2 cycles after the push edge. busy deasserts after 40 cycles.
2. CLKS_PER_BIT=4, FIFO_DEPTH=4, push 0x44,0x33,0x22,0x11,0x55 on consecutive cycles:
   - first byte popped immediately;
   - fifo_count=4 and full=1 after the 5th push;
   - six inValid cycles with a 6th byte 0x66 → inReady=0 on that cycle;
   - 0x66 is accepted on the cycle after the first frame's final STOP pop;
   - all six frames are back-to-back with no idle gap, in order.
3. PARITY_EN=1, PARITY_ODD=0, push 0x07 → 11-bit frame with parity bit 1. Repeat with PARITY_ODD=1 → parity bit 0.
4. Assert rst for 1 cycle midway through bit 3 of a frame with 2 bytes queued → next cycle tx=1, fifo_count=0, busy=0. No further frames follow without new pushes.
5. Hold inValid high with data_in=0x3C and no pops possible (FIFO full) for 20 cycles → fifo_count stays 4, and exactly one 0x3C is enqueued when space frees.
6. Push and pop on the same cycle at fifo_count=2 → fifo_count stays 2, and output byte order equals input order over 8 bytes, including pointer wrap.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // 100 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = baud_div(100_000_000, 115_200);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_fifo.sv
// Small synchronous byte FIFO; occupancy counter keeps full/empty unambiguous at pointer wrap.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [UART_DATA_W-1:0]      din,
    input  logic                        pop,
    output logic [UART_DATA_W-1:0]      dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: byte FIFO front end feeding an 8N1 / 8E1 / 8O1 serializer.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inValid,
    input  logic [UART_DATA_W-1:0]        data_in,
    output logic                          inReady,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);

    localparam int                    CW        = $clog2(CLKS_PER_BIT);
    localparam int                    BW        = $clog2(UART_DATA_W);
    localparam logic [CW-1:0]         BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]         LAST_BIT  = BW'(UART_DATA_W - 1);
    localparam logic                  PAR_INV   = (PARITY_ODD != 0);

    tx_state_t              state, state_n;
    logic [CW-1:0]          baud, baud_n;
    logic [BW-1:0]          bit_idx, bit_n;
    logic [UART_DATA_W-1:0] shift, shift_n;
    logic                   par, par_n;
    logic                   tx_n;
    logic                   pop;
    logic                   baud_last;
    logic [UART_DATA_W-1:0] fifo_dout;
    logic                   fifo_empty;

    assign inReady   = !full && !rst;
    assign busy      = (state != IDLE);
    assign baud_last = (baud == BAUD_LAST);

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inValid && inReady),
        .din   (data_in),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // tx_n follows the current state, so the registered line lags the FSM by one cycle
    always_comb begin
        state_n = state;
        baud_n  = baud_last ? '0 : baud + 1'b1;
        bit_n   = bit_idx;
        shift_n = shift;
        par_n   = par;
        pop     = 1'b0;
        tx_n    = 1'b1;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_last) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud_last) begin
                    shift_n = shift >> 1;
                    bit_n   = bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT)
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_n = par;
                if (baud_last) state_n = STOP;
            end
            STOP: begin
                tx_n = 1'b1;
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Parity is captured at load time since the shift register is consumed during DATA
        if (pop) begin
            shift_n = fifo_dout;
            par_n   = (^fifo_dout) ^ PAR_INV;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par     <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            tx      <= tx_n;
        end
    end

endmodule
